// File: rtl/sp_bram_inf_init.sv
// sp_bram_inf_init
// Single-port inferred block RAM with per-byte write enables and a selectable
// read-during-write behaviour. Because BRAM contents cannot be reset, a clear
// engine writes G_INIT to every word after reset or on a clr request. The
// read-valid strobe marks each new dout. An optional output register adds one
// cycle of latency.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (control and output regs only)
//   en        in   access request, honoured only while rdy=1
//   we        in   G_NBE byte-lane write enables, all zero = read
//   addr      in   word address
//   din       in   write data
//   clr       in   single-cycle clear request
//   rdy       out  1 = accepting accesses, 0 = clear engine running
//   dout      out  read data
//   dout_vld  out  one-cycle strobe marking a new dout
module sp_bram_inf_init #(
  parameter int                  G_ADDR  = 6,
  parameter int                  G_WIDTH = 32,
  parameter int                  G_BYTE  = 8,
  parameter int                  G_MODE  = 0,
  parameter int                  G_OREG  = 0,
  parameter logic [G_WIDTH-1:0]  G_INIT  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [G_WIDTH/G_BYTE-1:0]     we,
  input  logic [G_ADDR-1:0]             addr,
  input  logic [G_WIDTH-1:0]            din,
  input  logic                          clr,
  output logic                          rdy,
  output logic [G_WIDTH-1:0]            dout,
  output logic                          dout_vld
);

  localparam int                G_NBE    = G_WIDTH / G_BYTE;
  localparam int                G_DEPTH  = 2 ** G_ADDR;
  localparam logic [G_ADDR-1:0] ADDR_ONE = {{(G_ADDR-1){1'b0}}, 1'b1};
  localparam logic [G_ADDR-1:0] ADDR_LST = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [G_ADDR-1:0]   cnt_q, cnt_d;
  logic                vld1_q, vld1_d;
  logic                seen_q, seen_d;
  logic                acc;
  logic                upd;
  logic                init_wr;
  logic [G_WIDTH-1:0]  dout1;

  logic [G_WIDTH-1:0]  mem [G_DEPTH];
  logic [G_WIDTH-1:0]  rdata_q;

  always_comb begin
    acc     = (state_q == S_RUN) && en;
    // No-change mode leaves dout alone on any write.
    upd     = acc && !((G_MODE == 2) && (|we));
    init_wr = (state_q == S_INIT) && !rst;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + ADDR_ONE;
        if (cnt_q == ADDR_LST) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (clr) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
    endcase
    vld1_d = upd;
    // rdata_q has no reset; dout reads as zero until the first real result.
    seen_d = seen_q | upd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      vld1_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld1_q  <= vld1_d;
      seen_q  <= seen_d;
    end
  end

  // Stage 1: RAM array and its read register (no reset so it maps onto BRAM).
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt_q] <= G_INIT;
    end else if (acc) begin
      for (int i = 0; i < G_NBE; i++) begin
        if (we[i]) begin
          mem[addr][i*G_BYTE +: G_BYTE] <= din[i*G_BYTE +: G_BYTE];
        end
      end
    end
    if (upd) begin
      for (int i = 0; i < G_NBE; i++) begin
        // Write-first forwards written lanes; read-first and no-change see the old word.
        if ((G_MODE == 0) && we[i]) begin
          rdata_q[i*G_BYTE +: G_BYTE] <= din[i*G_BYTE +: G_BYTE];
        end else begin
          rdata_q[i*G_BYTE +: G_BYTE] <= mem[addr][i*G_BYTE +: G_BYTE];
        end
      end
    end
  end

  assign dout1 = seen_q ? rdata_q : '0;
  assign rdy   = (state_q == S_RUN);

  // Stage 2: optional output register, keeps draining through clear.
  if (G_OREG != 0) begin : g_oreg
    logic [G_WIDTH-1:0] dout_q, dout_d;
    logic               dout_vld_q, dout_vld_d;

    always_comb begin
      dout_d     = vld1_q ? dout1 : dout_q;
      dout_vld_d = vld1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q     <= '0;
        dout_vld_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        dout_vld_q <= dout_vld_d;
      end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
  end else begin : g_noreg
    assign dout     = dout1;
    assign dout_vld = vld1_q;
  end

endmodule

// File: tb/tb_sp_bram_inf_init.sv
// Testbench for sp_bram_inf_init: three instances (write-first, read-first
// with output register and non-zero init, no-change) share one stimulus
// stream and are each compared against a per-word reference model.
module tb_sp_bram_inf_init;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [3:0]  we  = '0;
  logic [3:0]  addr = '0;
  logic [31:0] din = '0;
  logic        clr = 1'b0;

  logic        rdy_w  [3];
  logic [31:0] dout_w [3];
  logic        vld_w  [3];

  always #5 clk = ~clk;

  sp_bram_inf_init #(.G_ADDR(4), .G_WIDTH(32), .G_BYTE(8), .G_MODE(0), .G_OREG(0),
                     .G_INIT(32'h0000_0000)) u_wf (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .clr(clr),
    .rdy(rdy_w[0]), .dout(dout_w[0]), .dout_vld(vld_w[0]));

  sp_bram_inf_init #(.G_ADDR(4), .G_WIDTH(32), .G_BYTE(8), .G_MODE(1), .G_OREG(1),
                     .G_INIT(32'hA5A5_A5A5)) u_rf (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .clr(clr),
    .rdy(rdy_w[1]), .dout(dout_w[1]), .dout_vld(vld_w[1]));

  sp_bram_inf_init #(.G_ADDR(4), .G_WIDTH(32), .G_BYTE(8), .G_MODE(2), .G_OREG(0),
                     .G_INIT(32'h0000_0000)) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .clr(clr),
    .rdy(rdy_w[2]), .dout(dout_w[2]), .dout_vld(vld_w[2]));

  // Reference model state, one slot per instance.
  int          md [3];
  logic        op [3];
  logic [31:0] iv [3];
  logic [31:0] m_mem [3][16];
  int          m_busy [3];
  logic [31:0] m_dout [3];
  logic        m_vld  [3];
  logic [31:0] m_pdata [3];
  logic        m_pvld  [3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k]  = 16;
    m_dout[k]  = '0;
    m_vld[k]   = 1'b0;
    m_pdata[k] = '0;
    m_pvld[k]  = 1'b0;
  endtask

  // One clock edge of behaviour, using the inputs present at that edge.
  task automatic model_edge();
    logic [31:0] old_w, new_w, rd;
    logic        rv;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        model_reset(k);
      end else begin
        rv = 1'b0;
        rd = '0;
        if (m_busy[k] > 0) begin
          m_mem[k][16 - m_busy[k]] = iv[k];
          m_busy[k]--;
        end else begin
          if (en) begin
            old_w = m_mem[k][addr];
            new_w = old_w;
            for (int b = 0; b < 4; b++)
              if (we[b]) new_w[b*8 +: 8] = din[b*8 +: 8];
            m_mem[k][addr] = new_w;
            if (md[k] == 0) begin
              rv = 1'b1; rd = new_w;
            end else if (md[k] == 1) begin
              rv = 1'b1; rd = old_w;
            end else if (we == 4'h0) begin
              rv = 1'b1; rd = old_w;
            end
          end
          if (clr) m_busy[k] = 16;
        end
        if (op[k]) begin
          m_vld[k] = m_pvld[k];
          if (m_pvld[k]) m_dout[k] = m_pdata[k];
          m_pvld[k]  = rv;
          m_pdata[k] = rd;
        end else begin
          m_vld[k] = rv;
          if (rv) m_dout[k] = rd;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rdy%0d", k), {31'b0, rdy_w[k]}, {31'b0, (m_busy[k] == 0)});
      chk($sformatf("vld%0d", k), {31'b0, vld_w[k]}, {31'b0, m_vld[k]});
      chk($sformatf("dout%0d", k), dout_w[k], m_dout[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [3:0] a,
                       input logic [31:0] d, input logic c);
    en = e; we = w; addr = a; din = d; clr = c;
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) model_reset(k);
    #1;
    compare_all();
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    md[0] = 0; op[0] = 1'b0; iv[0] = 32'h0000_0000;
    md[1] = 1; op[1] = 1'b1; iv[1] = 32'hA5A5_A5A5;
    md[2] = 2; op[2] = 1'b0; iv[2] = 32'h0000_0000;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++) m_mem[k][a] = '0;

    #2;
    do_rst(2);
    for (int i = 0; i < 16; i++) step();
    chk("clear_done", {31'b0, rdy_w[0]}, 32'd1);

    // Every word reads back as the init value.
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'h0, 4'(a), 32'h0, 1'b0);
      step();
      chk("init_rd", dout_w[0], 32'h0);
    end
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    step();
    step();
    chk("init_rd_a5", dout_w[1], 32'hA5A5_A5A5);

    // Write-first with byte lanes.
    drive(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0); step();
    chk("wf_full", dout_w[0], 32'hDEAD_BEEF);
    chk("wf_vld", {31'b0, vld_w[0]}, 32'd1);
    drive(1'b1, 4'b0101, 4'd3, 32'h1122_3344, 1'b0); step();
    chk("wf_lane", dout_w[0], 32'hDE22_BE44);
    drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0); step();
    chk("wf_rd", dout_w[0], 32'hDE22_BE44);

    // Read-first and no-change.
    drive(1'b1, 4'hF, 4'd5, 32'h1234_5678, 1'b0); step();
    drive(1'b1, 4'hF, 4'd5, 32'hCAFE_F00D, 1'b0); step();
    chk("nc_vld", {31'b0, vld_w[2]}, 32'd0);
    chk("nc_hold", dout_w[2], 32'hDE22_BE44);
    drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b0); step();
    chk("rf_old", dout_w[1], 32'h1234_5678);
    chk("nc_rd", dout_w[2], 32'hCAFE_F00D);
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0); step();
    chk("rf_new", dout_w[1], 32'hCAFE_F00D);
    step();
    chk("rf_vld_drop", {31'b0, vld_w[1]}, 32'd0);

    // Clear with a simultaneous write; accesses during clear are ignored.
    drive(1'b1, 4'hF, 4'd7, 32'h0000_FFFF, 1'b1); step();
    chk("clr_wr", dout_w[0], 32'h0000_FFFF);
    chk("clr_wr_vld", {31'b0, vld_w[0]}, 32'd1);
    chk("clr_rdy", {31'b0, rdy_w[0]}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom_range(1)), 4'hF, 4'd7, $urandom, 1'b0);
      step();
    end
    chk("clr_rdy_back", {31'b0, rdy_w[0]}, 32'd1);
    drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b0); step();
    chk("clr_rd7", dout_w[0], 32'h0);

    // Reset in the middle of a clear restarts it.
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    do_rst(1);
    repeat (8) step();
    do_rst(1);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 14) chk("rst_rdy_lo", {31'b0, rdy_w[0]}, 32'd0);
    end
    chk("rst_rdy_hi", {31'b0, rdy_w[0]}, 32'd1);

    // Back-to-back reads through the output register.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 4'h0, 4'(i), 32'h0, 1'b0);
      else       drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
      step();
      chk("oreg_vld", {31'b0, vld_w[1]}, {31'b0, (i >= 1 && i <= 3)});
      if (i >= 1 && i <= 3) chk("oreg_dout", dout_w[1], 32'hA5A5_A5A5);
    end

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(3) != 0),
            ($urandom_range(1) != 0) ? 4'h0 : 4'($urandom_range(15)),
            4'($urandom_range(15)), $urandom, ($urandom_range(63) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
